// File: rtl/board_scanner_if.sv
// Signal bundle between the board scanner, its scan requester and the digit predictor.
// The master modport is the scanner's view; slave is the environment's view.
interface board_scanner_if;
  logic         scan_start;
  logic [3:0]   cell_row;
  logic [3:0]   cell_col;
  logic         pred_start;
  logic         pred_finish;
  logic [3:0]   pred_number;
  logic [323:0] board;
  logic         board_valid;
  logic         busy;
  logic         timeout_err;

  modport master (
    input  scan_start, pred_finish, pred_number,
    output cell_row, cell_col, pred_start, board, board_valid, busy, timeout_err
  );

  modport slave (
    output scan_start, pred_finish, pred_number,
    input  cell_row, cell_col, pred_start, board, board_valid, busy, timeout_err
  );
endinterface

// File: rtl/board_scanner.sv
// Walks the 9x9 sudoku grid cell by cell, asks the digit predictor for each cell
// and assembles the 81 results into a packed 324-bit board.
module board_scanner #(
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  board_scanner_if.master   bus
);

  localparam int              TW           = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [3:0]      SETTLE_LAST  = 4'(SETTLE - 1);
  localparam logic [TW-1:0]   TIMEOUT_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_START,
    S_WAIT,
    S_STORE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     row_q, row_d;
  logic [3:0]     col_q, col_d;
  logic [6:0]     idx_q, idx_d;
  logic [3:0]     settle_cnt_q, settle_cnt_d;
  logic [TW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [3:0]     digit_q, digit_d;
  logic [323:0]   board_q, board_d;
  logic           board_valid_q, board_valid_d;
  logic           busy_q, busy_d;
  logic           timeout_err_q, timeout_err_d;

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case can infer a latch.
    state_d       = state_q;
    row_d         = row_q;
    col_d         = col_q;
    idx_d         = idx_q;
    settle_cnt_d  = settle_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    digit_d       = digit_q;
    board_d       = board_q;
    board_valid_d = board_valid_q;
    busy_d        = busy_q;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.scan_start) begin
          row_d         = 4'd0;
          col_d         = 4'd0;
          idx_d         = 7'd0;
          settle_cnt_d  = 4'd0;
          board_valid_d = 1'b0;
          timeout_err_d = 1'b0;
          busy_d        = 1'b1;
          state_d       = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = 4'd0;
          state_d      = S_START;
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      S_START: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        // A finish on the last permitted cycle still wins over the timeout.
        if (bus.pred_finish) begin
          digit_d = bus.pred_number;
          state_d = S_STORE;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          digit_d       = 4'd0;
          timeout_err_d = 1'b1;
          state_d       = S_STORE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      S_STORE: begin
        board_d[{idx_q, 2'b00} +: 4] = (digit_q > 4'd9) ? 4'd0 : digit_q;
        state_d                      = S_DRAIN;
      end
      S_DRAIN: begin
        if (!bus.pred_finish) begin
          if (col_q == 4'd8) begin
            if (row_q == 4'd8) begin
              state_d = S_DONE;
            end else begin
              col_d   = 4'd0;
              row_d   = row_q + 4'd1;
              idx_d   = idx_q + 7'd1;
              state_d = S_SETTLE;
            end
          end else begin
            col_d   = col_q + 4'd1;
            idx_d   = idx_q + 7'd1;
            state_d = S_SETTLE;
          end
        end
      end
      S_DONE: begin
        board_valid_d = 1'b1;
        busy_d        = 1'b0;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments only, so every register sees pre-edge values.
    if (rst) begin
      state_q       <= S_IDLE;
      row_q         <= 4'd0;
      col_q         <= 4'd0;
      idx_q         <= 7'd0;
      settle_cnt_q  <= 4'd0;
      wait_cnt_q    <= '0;
      digit_q       <= 4'd0;
      // NOTE: the board is a flop bank, not a RAM, and its cleared state is visible, so it is reset.
      board_q       <= '0;
      board_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      col_q         <= col_d;
      idx_q         <= idx_d;
      settle_cnt_q  <= settle_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      digit_q       <= digit_d;
      board_q       <= board_d;
      board_valid_q <= board_valid_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.cell_row    = row_q;
  assign bus.cell_col    = col_q;
  assign bus.pred_start  = (state_q == S_START);
  assign bus.board       = board_q;
  assign bus.board_valid = board_valid_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
